// File: rtl/bus_arbiter_rr.sv
// Round-robin N-master bus arbiter with registered one-hot grant and direct hand-over.
// Optional owner preemption after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned MAX_HOLD    = 16,
  localparam int unsigned ID_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [ID_W-1:0]        m_grant_id,
  output logic                   m_busy
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
    $error("bus_arbiter_rr: NUM_MASTERS must be in 2..16");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("bus_arbiter_rr: MAX_HOLD must be >= 2");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [ID_W-1:0]        grant_id_q;
  logic [ID_W-1:0]        last_q;
  logic                   busy_q;

  logic [NUM_MASTERS-1:0] cand;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_vld;
  logic [ID_W-1:0]        idx_id;
  int unsigned            idx;
  logic                   owner_req;
  logic                   preempt;
  logic                   take;

  // The current owner is masked out, so a hit always means a different master.
  // While granted, last_q equals the owner, so one search serves both states.
  always_comb begin
    cand     = m_req & ~grant_q;
    pick_vld = 1'b0;
    pick_id  = '0;
    pick_oh  = '0;
    idx      = 0;
    idx_id   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx    = (32'(last_q) + 32'd1 + i) % NUM_MASTERS;
      idx_id = ID_W'(idx);
      if (!pick_vld && cand[idx_id]) begin
        pick_vld = 1'b1;
        pick_id  = idx_id;
      end
    end
    pick_oh[pick_id] = pick_vld;
  end

  assign owner_req = m_req[grant_id_q];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q;

  assign preempt = (hold_q == HoldMax) && pick_vld;

  // Counts cycles of the current ownership; saturates when nobody is waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (take) begin
      hold_q <= '0;
    end else if (state_q == StGrant && hold_q != HoldMax) begin
      hold_q <= hold_q + HOLD_W'(1);
    end
  end
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    take = 1'b0;
    unique case (state_q)
      StIdle:  take = pick_vld;
      StGrant: take = pick_vld && (!owner_req || preempt);
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      last_q     <= ID_W'(NUM_MASTERS - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (take) begin
            state_q    <= StGrant;
            grant_q    <= pick_oh;
            grant_id_q <= pick_id;
            busy_q     <= 1'b1;
            last_q     <= pick_id;
          end
        end
        StGrant: begin
          if (take) begin
            grant_q    <= pick_oh;
            grant_id_q <= pick_id;
            last_q     <= pick_id;
          end else if (!owner_req) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_grant    = grant_q;
  assign m_grant_id = grant_id_q;
  assign m_busy     = busy_q;

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Parametrised N-master bus arbiter for the factorial computation system bus. It grants exactly one master at a time and holds the grant while that master keeps requesting. Contending requests are served round-robin, with direct hand-over and no idle cycle between owners. It sits between the bus masters (testbench/host master, factorial core DMA, future masters) and the bus address/data mux, which it steers via m_grant_id.

Parameters:
NUM_MASTERS, 2, number of requesting masters; legal range 2..16.
MAX_HOLD, 16, maximum consecutive grant cycles per owner while others wait; used only with ARB_TIMEOUT_EN; legal range >=2.
ID_W, $clog2(NUM_MASTERS), width of m_grant_id; derived, not to be overridden.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
m_req  input  NUM_MASTERS  per-master request; bit i = master i.
m_grant  output  NUM_MASTERS  registered one-hot grant; all-zero when bus idle.
m_grant_id  output  ID_W  index of current owner; 0 when idle; valid only when m_busy=1.
m_busy  output  1  registered; 1 when any m_grant bit is set.

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. On reset: m_grant=0, m_grant_id=0, m_busy=0, state=IDLE, last-owner pointer=NUM_MASTERS-1 (master 0 wins first), hold counter=0.
- All outputs are registered. Grant latency is 1 cycle: request seen at edge N gives grant after edge N+1. Release latency is 1 cycle: owner req low at edge N clears or moves the grant at edge N+1.
- Two states: IDLE and GRANT.
- IDLE, m_req==0: stay in IDLE.
- IDLE, m_req!=0: go to GRANT. Owner = first set bit searching upward from (last+1) mod NUM_MASTERS, with wrap-around.
- GRANT(owner k), m_req[k]==1: stay with owner k. Other requests are ignored; no preemption unless the optional feature is enabled.
- GRANT(k), m_req[k]==0, other bits set: hand over directly to the next requester, searching from (k+1) mod NUM_MASTERS. The grant moves in one edge with no all-zero cycle between owners.
- GRANT(k), m_req==0: go to IDLE; m_grant=0.
- last-owner pointer updates to the new owner on every grant assignment. It is kept across IDLE periods, so fairness survives idle gaps.
- m_grant is always one-hot or zero; never more than one bit is set. m_grant_id and m_busy always match m_grant.
- Request bits for non-owners may toggle freely; the arbiter samples them only at hand-over decisions.
- Asserting reset mid-grant clears all outputs immediately (asynchronously), not at the next clock.
- NUM_MASTERS=2 with only master 0 requesting must reproduce the single-master grant/release timing exactly (grant 1 cycle after req, drop 1 cycle after req low).

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a hold counter clears on every grant assignment and increments each cycle in GRANT. When the counter reaches MAX_HOLD-1 and any other m_req bit is set, the grant moves at the next edge to the next requester searching from k+1, even though m_req[k] is still high. The preempted master re-enters rotation normally. With no competing request, the owner keeps the grant and the counter saturates at MAX_HOLD-1.
- Not defined: no counter is present and owners hold indefinitely. MAX_HOLD is ignored.

Test Plan:
1. Reset with m_req=all ones held -> while reset_n=0, m_grant=0, m_grant_id=0, m_busy=0; first edge after release gives m_grant=...0001.
2. NUM_MASTERS=2, m_req=2'b01 raised before edge 1 and dropped before edge 5 -> m_grant=01 from edge 1 through edge 4; m_grant=00 at edge 5; m_busy tracks it.
3. NUM_MASTERS=4, m_req=4'b1111 after reset, each owner drops its req for one cycle after 3 grant cycles -> grant sequence 0001,0010,0100,1000,0001 with m_grant_id 0,1,2,3,0 and no zero cycle between owners.
4. Without macro: m_req=2'b11 held 40 cycles -> m_grant=01 for all 40 cycles; drop req0 -> m_grant=10 at the next edge.
5. With ARB_TIMEOUT_EN, MAX_HOLD=8: m_req=2'b11 held continuously -> grant alternates 01 and 10 every 8 cycles. With m_req=2'b01 only, the grant stays 01 indefinitely.
6. Mid-grant async reset: owner 2 granted, reset_n pulsed low between edges -> outputs go to 0 before the next edge. After release, m_req=4'b0110 -> grant 0010 (pointer reset, so master 1 wins before master 2).
